// File: rtl/aes_block_packer_if.sv
// Word-in / block-out handshake bundle between the plaintext streamer, the packer and the AES engine.
interface aes_block_packer_if #(
  parameter int IN_W  = 32,
  parameter int BLK_W = 128
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
  logic             blk_ready;

  // master: word source plus block sink; slave: the packer itself
  modport master (
    output in_data, in_valid, blk_ready,
    input  in_ready, blk_data, blk_valid
  );

  modport slave (
    input  in_data, in_valid, blk_ready,
    output in_ready, blk_data, blk_valid
  );
endinterface

// File: rtl/aes_block_packer.sv
// Packs IN_W-bit words into BLK_W-bit AES blocks (first word at the MSB) and counts blocks per job.
// Define AES_PACK_BYTESWAP_EN to byte-reverse each word before placement.
module aes_block_packer #(
  parameter int IN_W  = 32,
  parameter int BLK_W = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_blocks_i,
  aes_block_packer_if.slave bus,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blk_cnt_o
);
  localparam int WORDS = BLK_W / IN_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] nblk_q, nblk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             done_q, done_d;
  logic [IN_W-1:0]  word;

`ifdef AES_PACK_BYTESWAP_EN
  // Little-endian memory word -> AES byte order: byte 0 goes to the top of the slot
  always_comb begin
    word = '0;
    for (int b = 0; b < IN_W / 8; b++) begin
      word[IN_W-1-8*b -: 8] = bus.in_data[8*b +: 8];
    end
  end
`else
  assign word = bus.in_data;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nblk_d  = nblk_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_d = '0;
            if (n_blocks_i != '0) begin
              nblk_d  = n_blocks_i;
              state_d = S_FILL;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            blk_d[BLK_W-1-int'(idx_q)*IN_W -: IN_W] = word;
            if (idx_q == IDX_W'(WORDS - 1)) begin
              idx_d   = '0;
              state_d = S_HOLD;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.blk_ready) begin
            cnt_d   = cnt_q + 1'b1;
            done_d  = (cnt_d == nblk_q);
            state_d = done_d ? S_IDLE : S_FILL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nblk_q  <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nblk_q  <= nblk_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.blk_valid = (state_q == S_HOLD);
  assign bus.blk_data  = blk_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign blk_cnt_o     = cnt_q;
endmodule
